step_seg_sched: RTL

STEP_SEG_SCHED -- requirements
Module: step_seg_sched

---
 rtl/step_seg_sched.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/step_seg_sched.sv
// -----------------------------------------------------------------------------
// step_seg_sched
//
// Segment-queued step pulse scheduler. Each queued segment is a
// {period, steps} pair. The segment produces `steps` step pulses spaced
// period+1 run-enabled clocks apart. Segments execute back to back, with a
// single LOAD cycle between them.
//
// Ports
//   clk        system clock, all logic on posedge
//   aclr_n     asynchronous active-low reset
//   wr         segment write strobe (accepted when full=0)
//   wr_period  segment period, step interval is wr_period+1 clocks
//   wr_steps   number of steps in the segment
//   run        level: 1 = execute, 0 = pause (counters hold)
//   abort      synchronous flush: queue emptied, FSM to IDLE, overflow cleared
//   full       queue holds DEPTH entries
//   level      number of queued entries that are not yet loaded
//   overflow   sticky: a write was rejected because the queue was full
//   busy       FSM is not IDLE
//   step       one-clock step pulse
//   seg_done   one-clock pulse coincident with the last step of a segment
//   all_done   one-clock pulse when the queue drains and the FSM returns to IDLE
// -----------------------------------------------------------------------------
module step_seg_sched #(
    parameter int CNT_WIDTH  = 16,
    parameter int STEP_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    aclr_n,
    input  logic                    wr,
    input  logic [CNT_WIDTH-1:0]    wr_period,
    input  logic [STEP_WIDTH-1:0]   wr_steps,
    input  logic                    run,
    input  logic                    abort,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    busy,
    output logic                    step,
    output logic                    seg_done,
    output logic                    all_done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int ENT_W = CNT_WIDTH + STEP_WIDTH;

    localparam logic [PTR_W-1:0]      PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
    localparam logic [LVL_W-1:0]      LVL_ZERO  = {LVL_W{1'b0}};
    localparam logic [LVL_W-1:0]      LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0]      LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] STEP_ZERO = {STEP_WIDTH{1'b0}};
    localparam logic [STEP_WIDTH-1:0] STEP_ONE  = STEP_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;

    logic [ENT_W-1:0]        mem_r [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [LVL_W-1:0]        level_r;
    logic [LVL_W-1:0]        level_next_s;
    logic                    full_r;
    logic                    overflow_r;
    logic                    busy_r;

    logic [CNT_WIDTH-1:0]    period_r;
    logic [CNT_WIDTH-1:0]    div_cnt_r;
    logic [STEP_WIDTH-1:0]   steps_left_r;

    logic                    step_r;
    logic                    seg_done_r;
    logic                    all_done_r;
    logic                    step_s;
    logic                    seg_done_s;
    logic                    all_done_s;

    logic                    push_s;
    logic                    reject_s;
    logic                    pop_s;
    logic                    wrap_s;
    logic                    last_s;
    logic [CNT_WIDTH-1:0]    head_period_s;
    logic [STEP_WIDTH-1:0]   head_steps_s;

    // Full is judged on the registered flag, so a pop in the same cycle
    // does not make room for a write. Abort swallows any concurrent write.
    assign push_s   = wr & ~full_r & ~abort;
    assign reject_s = wr & full_r & ~abort;
    // LOAD is only ever entered with at least one entry queued.
    assign pop_s    = (state_r == ST_LOAD) & ~abort;

    assign head_period_s = mem_r[rd_ptr_r][ENT_W-1:STEP_WIDTH];
    assign head_steps_s  = mem_r[rd_ptr_r][STEP_WIDTH-1:0];

    // A wrap happens on a run-enabled RUN clock where the divider reaches
    // the loaded period; the one taking steps_left to zero ends the segment.
    assign wrap_s = (state_r == ST_RUN) & run & (div_cnt_r == period_r);
    assign last_s = wrap_s & (steps_left_r == STEP_ONE);

    // Next queue occupancy from the push/pop pair.
    always_comb begin
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_ONE;
            2'b01:   level_next_s = level_r - LVL_ONE;
            default: level_next_s = level_r;
        endcase
    end

    // Next-state and pulse decode for the IDLE/LOAD/RUN sequencer.
    always_comb begin
        state_s    = state_r;
        step_s     = 1'b0;
        seg_done_s = 1'b0;
        all_done_s = 1'b0;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run && (level_r != LVL_ZERO)) begin
                        state_s = ST_LOAD;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (head_steps_s == STEP_ZERO) begin
                        // Empty segment: discard it without producing pulses.
                        if (level_r > LVL_ONE) begin
                            state_s = ST_LOAD;
                        end else begin
                            state_s    = ST_IDLE;
                            all_done_s = 1'b1;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (wrap_s) begin
                        step_s = 1'b1;
                        if (last_s) begin
                            seg_done_s = 1'b1;
                            if (level_r != LVL_ZERO) begin
                                state_s = ST_LOAD;
                            end else begin
                                state_s    = ST_IDLE;
                                all_done_s = 1'b1;
                            end
                        end else begin
                            state_s = ST_RUN;
                        end
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register and its registered busy copy.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    // Queue payload storage; contents are only meaningful below level.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {wr_period, wr_steps};
        end
    end

    // Queue pointers, occupancy, full and sticky overflow.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            level_r    <= LVL_ZERO;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else if (abort) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            level_r    <= LVL_ZERO;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            level_r <= level_next_s;
            full_r  <= (level_next_s == LVL_FULL);
            if (reject_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Segment period, divider and remaining-step counters.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            period_r     <= CNT_ZERO;
            div_cnt_r    <= CNT_ZERO;
            steps_left_r <= STEP_ZERO;
        end else if (abort) begin
            period_r     <= CNT_ZERO;
            div_cnt_r    <= CNT_ZERO;
            steps_left_r <= STEP_ZERO;
        end else if (state_r == ST_LOAD) begin
            period_r     <= head_period_s;
            div_cnt_r    <= CNT_ZERO;
            steps_left_r <= head_steps_s;
        end else if ((state_r == ST_RUN) && run) begin
            if (wrap_s) begin
                div_cnt_r    <= CNT_ZERO;
                steps_left_r <= steps_left_r - STEP_ONE;
            end else begin
                div_cnt_r <= div_cnt_r + CNT_ONE;
            end
        end else begin
            // IDLE, or RUN paused: everything holds.
            div_cnt_r    <= div_cnt_r;
            steps_left_r <= steps_left_r;
        end
    end

    // Registered output pulses, one clock after the deciding edge.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            step_r     <= 1'b0;
            seg_done_r <= 1'b0;
            all_done_r <= 1'b0;
        end else begin
            step_r     <= step_s;
            seg_done_r <= seg_done_s;
            all_done_r <= all_done_s;
        end
    end

    assign full     = full_r;
    assign level    = level_r;
    assign overflow = overflow_r;
    assign busy     = busy_r;
    assign step     = step_r;
    assign seg_done = seg_done_r;
    assign all_done = all_done_r;

endmodule
